hamming_serializer_tx: RTL and testbench

Transmit-side partner of the 4-bit serial-to-parallel capture path. The block accepts a 4-bit data nibble through a valid/ready handshake and encodes it as a Hamming(7,4) codeword. It then shifts the codeword out one bit per clock, LSB (position 1) first, with framing strobes so the far-end deserializer/corrector can align. It sits between the data source and the serial link in the error-detection/correction datapath.

---
 rtl/hamming_pkg.sv | 19 +
 rtl/hamming_serializer_tx_encode.sv | 25 ++
 rtl/hamming_serializer_tx.sv | 80 ++++++++
 tb/tb_hamming_serializer_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types and constants for the transmit and receive/correct sides.
// Define HAMMING_PARITY_EXT_EN to append an overall parity bit (SECDED, 8-bit codeword).
package hamming_pkg;

`ifdef HAMMING_PARITY_EXT_EN
    localparam int CW_LEN = 8;
`else
    localparam int CW_LEN = 7;
`endif

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CW_LEN - 1);

    typedef logic [3:0]        nibble_t;
    typedef logic [CW_LEN-1:0] codeword_t;

    typedef enum logic {IDLE, SHIFT} tx_state_t;

endpackage

// File: rtl/hamming_serializer_tx_encode.sv
// Combinational Hamming(7,4) encoder; under HAMMING_PARITY_EXT_EN it also appends
// the overall parity bit as cw[7].
module hamming74_encode
    import hamming_pkg::*;
(
    input  nibble_t   data,
    output codeword_t cw
);

    logic p1, p2, p3;

    assign p1 = data[0] ^ data[1] ^ data[3];
    assign p2 = data[0] ^ data[2] ^ data[3];
    assign p3 = data[1] ^ data[2] ^ data[3];

    // cw[0] is codeword position 1, so parity bits sit at indices 0, 1 and 3
`ifdef HAMMING_PARITY_EXT_EN
    logic [6:0] base;
    assign base = {data[3], data[2], data[1], p3, data[0], p2, p1};
    assign cw   = {^base, base};
`else
    assign cw   = {data[3], data[2], data[1], p3, data[0], p2, p1};
`endif

endmodule

// File: rtl/hamming_serializer_tx.sv
// Hamming codeword serializer: accepts a nibble on load/ready and shifts its codeword
// out LSB first with frame strobes. HAMMING_PARITY_EXT_EN selects the 8-bit SECDED frame.
module hamming_serializer_tx
    import hamming_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic       frame_done
);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    codeword_t        shreg;
    codeword_t        cw_enc;
    logic             in_shift;
    logic             at_last;

    hamming74_encode u_encode (
        .data (data_in),
        .cw   (cw_enc)
    );

    assign in_shift = (state == SHIFT);
    assign at_last  = in_shift && (cnt == CNT_LAST);

    // Every output is a decode of registered state, so none depends on load/data_in
    assign ready       = (state == IDLE) || at_last;
    assign ser_valid   = in_shift;
    assign ser_out     = in_shift ? shreg[0] : IDLE_LEVEL;
    assign frame_start = in_shift && (cnt == '0);
    assign frame_done  = at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= cw_enc;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // Reloading on the last bit gives gap-free back-to-back frames
                        cnt <= '0;
                        if (load) begin
                            shreg <= cw_enc;
                        end else begin
                            shreg <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        shreg <= shreg >> 1;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    shreg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_serializer_tx.sv
// Self-checking bench for hamming_serializer_tx: randomized and directed stimulus
// against a queue-based model of the serial bit stream.
module tb_hamming_serializer_tx;
    import hamming_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic       load;
    logic       ready, ser_out, ser_valid, frame_start, frame_done;

    logic [3:0] data_in1;
    logic       load1;
    logic       ready1, ser_out1, ser_valid1, frame_start1, frame_done1;

    int n_checks;
    int n_fail;
    int cyc;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } ev_t;

    ev_t         q[$];
    logic [15:0] cap;
    int          cap_n;
    logic [7:0]  f1011, f1111;
    logic [15:0] mask;

    hamming_serializer_tx #(.IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    hamming_serializer_tx #(.IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in1), .load(load1),
        .ready(ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .frame_start(frame_start1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference codeword by Hamming position rule: parity at position p covers
    // every other position j with (j & p) != 0. Index k of result = position k.
    function automatic logic [7:0] ref_pos(input logic [3:0] d);
        logic [7:0] pos;
        logic       x;
        int         dp[4];
        dp[0] = 3; dp[1] = 5; dp[2] = 6; dp[3] = 7;
        pos = '0;
        for (int i = 0; i < 4; i++) pos[dp[i]] = d[i];
        for (int p = 1; p < 8; p = p * 2) begin
            x = 1'b0;
            for (int j = 1; j < 8; j++)
                if (((j & p) != 0) && (j != p)) x = x ^ pos[j];
            pos[p] = x;
        end
        return pos;
    endfunction

    task automatic push_frame(input logic [3:0] d);
        logic [7:0] pos;
        ev_t        e;
        pos = ref_pos(d);
        for (int k = 0; k < CW_LEN; k++) begin
            e.b = (k < 7) ? pos[k + 1] : ^pos[7:1];
            e.s = (k == 0);
            e.d = (k == CW_LEN - 1);
            q.push_back(e);
        end
    endtask

    // One clock: check outputs against the model, apply inputs, advance model and clock
    task automatic cycle(input logic ld, input logic [3:0] d);
        logic er, ev, eb, es, ed;
        load    = ld;
        data_in = d;
        er = (q.size() <= 1);
        if (q.size() > 0) begin
            ev = 1'b1; eb = q[0].b; es = q[0].s; ed = q[0].d;
        end else begin
            ev = 1'b0; eb = 1'b0; es = 1'b0; ed = 1'b0;
        end
        n_checks++;
        if (ready !== er) begin
            n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, er);
        end
        n_checks++;
        if (ser_valid !== ev) begin
            n_fail++; $display("FAIL ser_valid cyc=%0d got=%b exp=%b", cyc, ser_valid, ev);
        end
        n_checks++;
        if (ser_out !== eb) begin
            n_fail++; $display("FAIL ser_out cyc=%0d got=%b exp=%b", cyc, ser_out, eb);
        end
        n_checks++;
        if (frame_start !== es) begin
            n_fail++; $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, es);
        end
        n_checks++;
        if (frame_done !== ed) begin
            n_fail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, ed);
        end
        n_checks++;
        if ({ser_out1, ser_valid1, ready1} !== 3'b101) begin
            n_fail++; $display("FAIL idle_hi cyc=%0d got=%b exp=101", cyc, {ser_out1, ser_valid1, ready1});
        end
        if (ser_valid === 1'b1 && cap_n < 16) begin
            cap[cap_n] = ser_out;
            cap_n++;
        end
        if (q.size() > 0) void'(q.pop_front());
        if (ld && er) push_frame(d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if ({ready, ser_out, ser_valid, frame_start, frame_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s got=%b exp=10000", tag, {ready, ser_out, ser_valid, frame_start, frame_done});
        end
    endtask

    task automatic check_cap(input string tag, input int exp_n, input logic [15:0] exp_bits);
        n_checks++;
        if (cap_n !== exp_n) begin
            n_fail++; $display("FAIL %s_len got=%0d exp=%0d", tag, cap_n, exp_n);
        end
        n_checks++;
        if ((cap & ((16'(1) << exp_n) - 16'(1))) !== exp_bits) begin
            n_fail++; $display("FAIL %s_bits got=%h exp=%h", tag, cap, exp_bits);
        end
    endtask

    task automatic test_reset;
        load = 1'b0; data_in = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("reset_hold");
        reset = 1'b0;
        q.delete();
        cycle(1'b1, 4'b1011);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("reset_async");
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000);
    endtask

    task automatic test_single;
        cap = '0; cap_n = 0;
        cycle(1'b1, 4'b1011);
        for (int i = 0; i < CW_LEN + 2; i++) cycle(1'b0, 4'b0000);
        check_cap("single_1011", CW_LEN, 16'(f1011) & mask);
    endtask

    task automatic test_patterns;
        cap = '0; cap_n = 0;
        cycle(1'b1, 4'b1111);
        for (int i = 0; i < CW_LEN + 1; i++) cycle(1'b0, $urandom_range(15, 0));
        check_cap("ones_1111", CW_LEN, 16'(f1111) & mask);
        cap = '0; cap_n = 0;
        cycle(1'b1, 4'b0000);
        for (int i = 0; i < CW_LEN + 1; i++) cycle(1'b0, 4'b1111);
        check_cap("zeros_0000", CW_LEN, 16'h0000);
    endtask

    task automatic test_back_to_back;
        cap = '0; cap_n = 0;
        cycle(1'b1, 4'b1011);
        for (int i = 0; i < CW_LEN; i++) cycle(1'b1, 4'b1111);
        for (int i = 0; i < CW_LEN + 2; i++) cycle(1'b0, 4'b0000);
        check_cap("b2b", 2 * CW_LEN, ((16'(f1111) & mask) << CW_LEN) | (16'(f1011) & mask));
    endtask

    task automatic test_load_busy;
        cap = '0; cap_n = 0;
        cycle(1'b1, 4'b1011);
        for (int i = 0; i < CW_LEN - 1; i++) cycle(1'b1, 4'b0110);
        for (int i = 0; i < CW_LEN + 3; i++) cycle(1'b0, 4'b0110);
        check_cap("busy_ignore", CW_LEN, 16'(f1011) & mask);
    endtask

    task automatic test_idle;
        cap = '0; cap_n = 0;
        for (int i = 0; i < 20; i++) cycle(1'b0, $urandom_range(15, 0));
        n_checks++;
        if (cap_n !== 0) begin
            n_fail++; $display("FAIL idle_bits got=%0d exp=0", cap_n);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(2, 0) != 0), $urandom_range(15, 0));
        for (int i = 0; i < CW_LEN + 2; i++) cycle(1'b0, 4'b0000);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        cap = '0; cap_n = 0;
        load1 = 1'b0; data_in1 = 4'b0000;
        load = 1'b0; data_in = 4'b0000; reset = 1'b0;
        f1011 = 8'b0101_0101;
        f1111 = (CW_LEN == 8) ? 8'hFF : 8'h7F;
        mask  = (16'(1) << CW_LEN) - 16'(1);
        test_reset;
        test_single;
        test_patterns;
        test_back_to_back;
        test_load_busy;
        test_idle;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
